// File: rtl/spike_pkg.sv
// Shared constants and FSM encoding for the spike rate decoder.
package spike_pkg;
  localparam int RATE_W_DEF = 8;
  localparam int WIN_W_DEF  = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;
endpackage

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating up-counter; nxt_o is the post-increment value before clear.
import spike_pkg::*;

module sat_counter #(
  parameter int W = RATE_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    nxt_o = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}}))
      nxt_o = cnt_q + W'(1);
    cnt_d = clr_i ? '0 : nxt_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes over a latched window and hands the rate downstream
// through a valid/ready register with a sticky overrun flag.
import spike_pkg::*;

module spike_rate_decoder #(
  parameter int RATE_W = RATE_W_DEF,
  parameter int WIN_W  = WIN_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              spike_i,
  input  logic [WIN_W-1:0]  window_i,
  input  logic              ready_i,
  output logic [RATE_W-1:0] rate_o,
  output logic              valid_o,
  output logic              overrun_o,
  output logic              busy_o
);
  state_e            state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WIN_W-1:0]  cyc_q, cyc_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;

  logic              clr;
  logic              inc;
  logic              done;
  logic [WIN_W-1:0]  win_start;
  logic [RATE_W-1:0] spk_cnt;
  logic [RATE_W-1:0] spk_nxt;

  sat_counter #(.W(RATE_W)) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .inc_i (inc),
    .cnt_o (spk_cnt),
    .nxt_o (spk_nxt)
  );

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cyc_d     = cyc_q;
    rate_d    = rate_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    clr       = 1'b0;
    inc       = 1'b0;
    done      = 1'b0;
    win_start = (window_i == '0) ? WIN_W'(1) : window_i;

    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = COUNT;
          win_d   = win_start;
          cyc_d   = '0;
          clr     = 1'b1;
        end
      end
      COUNT: begin
        inc = spike_i;
        if (cyc_q == win_q - WIN_W'(1)) begin
          done = 1'b1;
          clr  = 1'b1;
          cyc_d = '0;
          if (en_i) win_d = win_start;
          else      state_d = IDLE;
        end else if (!en_i) begin
          state_d = IDLE;
          clr     = 1'b1;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + WIN_W'(1);
        end
      end
    endcase

    // A held, unaccepted result wins over a fresh one.
    if (done) begin
      if (!valid_q || ready_i) begin
        rate_d  = spk_nxt;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      win_q   <= WIN_W'(1);
      cyc_q   <= '0;
      rate_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cyc_q   <= cyc_d;
      rate_q  <= rate_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rate_o    = rate_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;
  assign busy_o    = busy_q;
endmodule
